key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 26 ++
 rtl/key_debounce.sv | 117 +++++++++++
 tb/tb_key_debounce.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Push-button bundle between the raw key inputs and their debounced level/strobe outputs.
interface key_debounce_if #(
  parameter int N_KEYS = 6
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_pulse;
  logic [N_KEYS-1:0] key_release;
  logic              any_pulse;

  modport master (
    output key_in,
    input  key_level,
    input  key_pulse,
    input  key_release,
    input  any_pulse
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_pulse,
    output key_release,
    output any_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key debouncer: two-flop synchronizer, then a qualify-by-stability FSM per channel
// emitting a registered level plus one-cycle press/release strobes.
//
// state     | meaning
// IDLE      | debounced level 0, input low
// PRESS_CHK | input high, counting stable cycles toward a press
// PRESSED   | debounced level 1, input high
// REL_CHK   | input low, counting stable cycles toward a release
module key_debounce #(
  parameter int N_KEYS        = 6,
  parameter int STABLE_CYCLES = 2_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  key_debounce_if.slave bus
);

  localparam int              CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } state_t;

  state_t            state [N_KEYS];
  logic [CW-1:0]     cnt   [N_KEYS];
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] pulse_q;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] press_done;
  logic              any_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.key_in;
      s2 <= s1;
    end
  end

  // Same condition that fires key_pulse, so any_pulse lands on the same edge.
  always_comb begin
    press_done = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      press_done[i] = (state[i] == PRESS_CHK) && s2[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      level_q   <= '0;
      pulse_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      pulse_q   <= '0;
      release_q <= '0;
      any_q     <= |press_done;
      for (int i = 0; i < N_KEYS; i++) begin
        case (state[i])
          IDLE: begin
            if (s2[i]) begin
              state[i] <= PRESS_CHK;
              cnt[i]   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s2[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] != CNT_MAX) begin
              cnt[i] <= cnt[i] + CW'(1);
            end else begin
              state[i]   <= PRESSED;
              level_q[i] <= 1'b1;
              pulse_q[i] <= 1'b1;
            end
          end
          PRESSED: begin
            if (!s2[i]) begin
              state[i] <= REL_CHK;
              cnt[i]   <= '0;
            end
          end
          REL_CHK: begin
            if (s2[i]) begin
              state[i] <= PRESSED;
            end else if (cnt[i] != CNT_MAX) begin
              cnt[i] <= cnt[i] + CW'(1);
            end else begin
              state[i]     <= IDLE;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_pulse   = pulse_q;
  assign bus.key_release = release_q;
  assign bus.any_pulse   = any_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (6 keys, 4 stable cycles): stimulus queues expected
// strobes with their cycle, a negedge monitor pops and checks every strobe it sees.
module tb_key_debounce;

  localparam int NK = 6;
  localparam int SC = 4;
  localparam int LAT = SC + 3;  // drive at negedge of cycle k -> strobe visible at cycle k+LAT

  typedef struct {
    int             cyc;
    logic [NK-1:0]  pulse;
    logic [NK-1:0]  rel;
    logic [NK-1:0]  lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  key_debounce_if #(.N_KEYS(NK)) bus ();

  key_debounce #(.N_KEYS(NK), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r,
                           input logic [NK-1:0] l);
    exp_t e;
    e.cyc = at; e.pulse = p; e.rel = r; e.lvl = l;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any strobe activity must match the head of the scoreboard, on the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_strobe: no strobe observed, expected at cycle %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (bus.key_pulse != '0 || bus.key_release != '0 || bus.any_pulse) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: pulse=%b release=%b any=%b, expected none (cycle %0d)",
                   bus.key_pulse, bus.key_release, bus.any_pulse, cyc);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("key_pulse", int'(bus.key_pulse), int'(e.pulse));
          chk("key_release", int'(bus.key_release), int'(e.rel));
          chk("any_pulse", int'(bus.any_pulse), int'(e.pulse != '0));
          chk("key_level", int'(bus.key_level), int'(e.lvl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.key_in = '0;
    rst_n = 1'b0;
    wait_neg(3);
    chk("rst_level", int'(bus.key_level), 0);
    chk("rst_pulse", int'(bus.key_pulse), 0);
    chk("rst_release", int'(bus.key_release), 0);
    chk("rst_any", int'(bus.any_pulse), 0);
    rst_n = 1'b1;
    wait_neg(3);

    // clean press on key 0
    bus.key_in[0] = 1'b1;
    expect_ev(cyc + LAT, 6'b000001, 6'b000000, 6'b000001);
    wait_neg(12);

    // bounce on key 2, then held
    bus.key_in[2] = 1'b1; wait_neg(2);
    bus.key_in[2] = 1'b0; wait_neg(2);
    bus.key_in[2] = 1'b1; wait_neg(2);
    bus.key_in[2] = 1'b0; wait_neg(2);
    bus.key_in[2] = 1'b1;
    expect_ev(cyc + LAT, 6'b000100, 6'b000000, 6'b000101);
    wait_neg(12);

    // key 1 press, then release with a one-cycle glitch
    bus.key_in[1] = 1'b1;
    expect_ev(cyc + LAT, 6'b000010, 6'b000000, 6'b000111);
    wait_neg(12);
    bus.key_in[1] = 1'b0; wait_neg(2);
    bus.key_in[1] = 1'b1; wait_neg(1);
    bus.key_in[1] = 1'b0;
    expect_ev(cyc + LAT, 6'b000000, 6'b000010, 6'b000101);
    wait_neg(12);

    // simultaneous press on keys 5:3
    bus.key_in[5:3] = 3'b111;
    expect_ev(cyc + LAT, 6'b111000, 6'b000000, 6'b111101);
    wait_neg(12);

    // release everything but key 4, then keep key 4 held for 100+ cycles
    bus.key_in = 6'b010000;
    expect_ev(cyc + LAT, 6'b000000, 6'b101101, 6'b010000);
    wait_neg(100);
    chk("long_hold_level", int'(bus.key_level), 6'b010000);
    bus.key_in[4] = 1'b0;
    expect_ev(cyc + LAT, 6'b000000, 6'b010000, 6'b000000);
    wait_neg(12);

    // reset while key_pulse[1] is high
    bus.key_in[1] = 1'b1;
    expect_ev(cyc + LAT, 6'b000010, 6'b000000, 6'b000010);
    wait_neg(LAT);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_strobe_pulse", int'(bus.key_pulse), 0);
    chk("rst_strobe_any", int'(bus.any_pulse), 0);
    chk("rst_strobe_level", int'(bus.key_level), 0);
    bus.key_in[1] = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(4);

    // reset mid-qualification (cnt=2 in PRESS_CHK), key 0 held through reset release
    bus.key_in[0] = 1'b1;
    wait_neg(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_level", int'(bus.key_level), 0);
    chk("rst_mid_pulse", int'(bus.key_pulse), 0);
    chk("rst_mid_release", int'(bus.key_release), 0);
    chk("rst_mid_any", int'(bus.any_pulse), 0);
    wait_neg(2);
    rst_n = 1'b1;
    expect_ev(cyc + LAT, 6'b000001, 6'b000000, 6'b000001);
    wait_neg(12);
    bus.key_in[0] = 1'b0;
    expect_ev(cyc + LAT, 6'b000000, 6'b000001, 6'b000000);
    wait_neg(12);

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
